// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port word memory between instruction fetch and data access.
// Data port has fixed priority; each access runs IDLE -> ISSUE -> WAIT(MEM_LAT) -> RESP.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned AW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  state_e          state_q,     state_d;
  owner_e          owner_q,     owner_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic            we_q,        we_d;
  logic            mem_en_q,    mem_en_d;
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     if_rdata_q,  if_rdata_d;
  logic [31:0]     dm_rdata_q,  dm_rdata_d;
  logic            if_ready_q,  if_ready_d;
  logic            dm_ready_q,  dm_ready_d;
  logic            busy_q,      busy_d;

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0],
                              dm_addr[31:AW+2], dm_addr[1:0]};

  // Next-state and output logic; requests are only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dm_req) begin
          owner_d     = OWN_DM;
          we_d        = dm_we;
          mem_addr_d  = dm_addr[AW+1:2];
          mem_wdata_d = dm_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          state_d     = S_ISSUE;
        end else if (if_req) begin
          owner_d     = OWN_IF;
          we_d        = 1'b0;
          mem_addr_d  = if_addr[AW+1:2];
          mem_en_d    = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          // Read data is valid only in the final wait cycle.
          if (!we_q) begin
            if (owner_q == OWN_DM) dm_rdata_d = mem_rdata;
            else                   if_rdata_d = mem_rdata;
          end
          if (owner_q == OWN_DM) dm_ready_d = 1'b1;
          else                   if_ready_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

  // Stalls feed the hazard unit directly, so they are combinational.
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 runs with MEM_LAT=2, instance 1 with MEM_LAT=1.
// Each instance has its own latency-accurate memory model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          if_req    [2];
  logic [31:0]   if_addr   [2];
  logic [31:0]   if_rdata  [2];
  logic          if_ready  [2];
  logic          dm_req    [2];
  logic          dm_we     [2];
  logic [31:0]   dm_addr   [2];
  logic [31:0]   dm_wdata  [2];
  logic [31:0]   dm_rdata  [2];
  logic          dm_ready  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [31:0]   mem_wdata [2];
  logic          stall_if  [2];
  logic          stall_mem [2];
  logic          busy      [2];

  int n_checks;
  int n_fail;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h2008_0005 : 32'(i);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : 1;
    logic [31:0] mem_q  [1024];
    logic [31:0] pipe_q [LAT];
    logic        pv_q   [LAT];
    logic [31:0] rdata_w;

    mem_port_arbiter #(.MEM_LAT(LAT), .AW(AW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_rdata  (if_rdata[g]),
      .if_ready  (if_ready[g]),
      .dm_req    (dm_req[g]),
      .dm_we     (dm_we[g]),
      .dm_addr   (dm_addr[g]),
      .dm_wdata  (dm_wdata[g]),
      .dm_rdata  (dm_rdata[g]),
      .dm_ready  (dm_ready[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (rdata_w),
      .stall_if  (stall_if[g]),
      .stall_mem (stall_mem[g]),
      .busy      (busy[g])
    );

    // Read data appears exactly LAT cycles after the issue cycle; poison otherwise.
    always @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < 1024; i++) mem_q[i] <= init_word(i);
        for (int i = 0; i < int'(LAT); i++) pv_q[i] <= 1'b0;
      end else begin
        if (mem_en[g] && mem_we[g]) mem_q[mem_addr[g]] <= mem_wdata[g];
        pipe_q[0] <= mem_q[mem_addr[g]];
        pv_q[0]   <= mem_en[g] && !mem_we[g];
        for (int i = 1; i < int'(LAT); i++) begin
          pipe_q[i] <= pipe_q[i-1];
          pv_q[i]   <= pv_q[i-1];
        end
      end
    end
    assign rdata_w = pv_q[LAT-1] ? pipe_q[LAT-1] : 32'hBAD0_BAD0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_window(input int d, input int n, output int n_if, output int n_dm,
                              output int n_en);
    n_if = 0; n_dm = 0; n_en = 0;
    for (int i = 0; i < n; i++) begin
      if (if_ready[d]) n_if++;
      if (dm_ready[d]) n_dm++;
      if (mem_en[d])   n_en++;
      step();
    end
  endtask

  // Fetch of byte 0x10 (word 4) on the MEM_LAT=2 instance, starting from IDLE.
  task automatic run_fetch(input string p);
    if_addr[0] = 32'h10;
    if_req[0]  = 1'b1;
    #1;
    check_eq({p, "_stall_t0"}, 32'(stall_if[0]), 32'd1);
    check_eq({p, "_busy_t0"},  32'(busy[0]),     32'd0);
    step();
    check_eq({p, "_en_t1"},    32'(mem_en[0]),   32'd1);
    check_eq({p, "_we_t1"},    32'(mem_we[0]),   32'd0);
    check_eq({p, "_addr_t1"},  32'(mem_addr[0]), 32'd4);
    check_eq({p, "_busy_t1"},  32'(busy[0]),     32'd1);
    step();
    check_eq({p, "_en_t2"},    32'(mem_en[0]),   32'd0);
    check_eq({p, "_stall_t2"}, 32'(stall_if[0]), 32'd1);
    step();
    check_eq({p, "_stall_t3"}, 32'(stall_if[0]), 32'd1);
    check_eq({p, "_rdy_t3"},   32'(if_ready[0]), 32'd0);
    step();
    check_eq({p, "_rdy_t4"},   32'(if_ready[0]), 32'd1);
    check_eq({p, "_rdata_t4"}, if_rdata[0],      32'h2008_0005);
    check_eq({p, "_stall_t4"}, 32'(stall_if[0]), 32'd0);
    check_eq({p, "_busy_t4"},  32'(busy[0]),     32'd1);
    if_req[0] = 1'b0;
    step();
    check_eq({p, "_rdy_t5"},   32'(if_ready[0]), 32'd0);
    check_eq({p, "_busy_t5"},  32'(busy[0]),     32'd0);
    check_eq({p, "_hold_t5"},  if_rdata[0],      32'h2008_0005);
  endtask

  initial begin
    int a, b, c;
    int last, nrdy, nen;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; if_addr[d] = '0;
      dm_req[d] = 1'b0; dm_we[d] = 1'b0; dm_addr[d] = '0; dm_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset values, and stall follows request while held in reset.
    check_eq("rst_if_ready",  32'(if_ready[0]),  32'd0);
    check_eq("rst_dm_ready",  32'(dm_ready[0]),  32'd0);
    check_eq("rst_if_rdata",  if_rdata[0],       32'd0);
    check_eq("rst_dm_rdata",  dm_rdata[0],       32'd0);
    check_eq("rst_mem_en",    32'(mem_en[0]),    32'd0);
    check_eq("rst_mem_addr",  32'(mem_addr[0]),  32'd0);
    check_eq("rst_busy",      32'(busy[0]),      32'd0);
    dm_req[0] = 1'b1;
    #1;
    check_eq("rst_stall_mem", 32'(stall_mem[0]), 32'd1);
    dm_req[0] = 1'b0;
    rst = 1'b1;
    step();

    // Scenario 1: single fetch.
    run_fetch("s1");

    // Scenario 2: simultaneous requests, data wins, fetch follows.
    if_addr[0] = 32'h8;  if_req[0] = 1'b1;
    dm_addr[0] = 32'h20; dm_we[0] = 1'b0; dm_req[0] = 1'b1;
    step();
    check_eq("s2_addr_t1",     32'(mem_addr[0]),  32'd8);
    check_eq("s2_en_t1",       32'(mem_en[0]),    32'd1);
    step(); step(); step();
    check_eq("s2_dmrdy_t4",    32'(dm_ready[0]),  32'd1);
    check_eq("s2_dmrdata_t4",  dm_rdata[0],       32'd8);
    check_eq("s2_ifrdy_t4",    32'(if_ready[0]),  32'd0);
    check_eq("s2_stallmem_t4", 32'(stall_mem[0]), 32'd0);
    check_eq("s2_stallif_t4",  32'(stall_if[0]),  32'd1);
    dm_req[0] = 1'b0;
    step();
    check_eq("s2_busy_t5",     32'(busy[0]),      32'd0);
    step();
    check_eq("s2_en_t6",       32'(mem_en[0]),    32'd1);
    check_eq("s2_addr_t6",     32'(mem_addr[0]),  32'd2);
    step(); step();
    check_eq("s2_stallif_t8",  32'(stall_if[0]),  32'd1);
    step();
    check_eq("s2_ifrdy_t9",    32'(if_ready[0]),  32'd1);
    check_eq("s2_ifrdata_t9",  if_rdata[0],       32'd2);
    if_req[0] = 1'b0;
    step();

    // Scenario 3: write, then read it back.
    dm_addr[0] = 32'h44; dm_wdata[0] = 32'hDEAD_BEEF; dm_we[0] = 1'b1; dm_req[0] = 1'b1;
    step();
    check_eq("s3_en_t1",       32'(mem_en[0]),    32'd1);
    check_eq("s3_we_t1",       32'(mem_we[0]),    32'd1);
    check_eq("s3_addr_t1",     32'(mem_addr[0]),  32'h11);
    check_eq("s3_wdata_t1",    mem_wdata[0],      32'hDEAD_BEEF);
    step();
    check_eq("s3_we_t2",       32'(mem_we[0]),    32'd0);
    step(); step();
    check_eq("s3_rdy_t4",      32'(dm_ready[0]),  32'd1);
    check_eq("s3_rdata_keep",  dm_rdata[0],       32'd8);
    dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    step();
    check_eq("s3_rdy_t5",      32'(dm_ready[0]),  32'd0);
    dm_req[0] = 1'b1;
    step(); step(); step(); step();
    check_eq("s3_rb_rdy",      32'(dm_ready[0]),  32'd1);
    check_eq("s3_rb_rdata",    dm_rdata[0],       32'hDEAD_BEEF);
    dm_req[0] = 1'b0;
    step();

    // Scenario 6: write whose request drops during WAIT still completes.
    dm_addr[0] = 32'h48; dm_wdata[0] = 32'h1234_5678; dm_we[0] = 1'b1; dm_req[0] = 1'b1;
    step(); step();
    dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    #1;
    check_eq("s6_stallmem",    32'(stall_mem[0]), 32'd0);
    count_window(0, 6, a, b, c);
    check_eq("s6_rdy_count",   32'(b),            32'd1);
    check_eq("s6_busy_after",  32'(busy[0]),      32'd0);
    check_eq("s6_rdata_keep",  dm_rdata[0],       32'hDEAD_BEEF);
    dm_req[0] = 1'b1;
    step(); step(); step(); step();
    check_eq("s6_rb_rdata",    dm_rdata[0],       32'h1234_5678);
    dm_req[0] = 1'b0;
    step();

    // Scenario 5: reset in the middle of a data read's WAIT.
    dm_addr[0] = 32'h10; dm_wdata[0] = 32'h5555_AAAA; dm_we[0] = 1'b0; dm_req[0] = 1'b1;
    step(); step();
    check_eq("s5_busy_pre",    32'(busy[0]),      32'd1);
    rst = 1'b0;
    dm_req[0] = 1'b0;
    #1;
    check_eq("s5_busy",        32'(busy[0]),      32'd0);
    check_eq("s5_if_rdata",    if_rdata[0],       32'd0);
    check_eq("s5_dm_rdata",    dm_rdata[0],       32'd0);
    check_eq("s5_mem_addr",    32'(mem_addr[0]),  32'd0);
    check_eq("s5_mem_wdata",   mem_wdata[0],      32'd0);
    check_eq("s5_dm_ready",    32'(dm_ready[0]),  32'd0);
    check_eq("s5_mem_en",      32'(mem_en[0]),    32'd0);
    step(); step();
    rst = 1'b1;
    count_window(0, 6, a, b, c);
    check_eq("s5_no_dmrdy",    32'(b),            32'd0);
    check_eq("s5_no_en",       32'(c),            32'd0);
    check_eq("s5_busy_after",  32'(busy[0]),      32'd0);
    run_fetch("s5f");

    // Scenario 4: held fetch on the MEM_LAT=1 instance, one access per 4 cycles.
    last = 0; nrdy = 0; nen = 0;
    if_addr[1] = 32'h0;
    if_req[1]  = 1'b1;
    for (int cy = 0; cy < 30 && nrdy < 3; cy++) begin
      if (mem_en[1]) nen++;
      if (if_ready[1]) begin
        check_eq("s4_rdata",   if_rdata[1],       32'(nrdy));
        check_eq("s4_spacing", 32'(cy - last),    (nrdy == 0) ? 32'd3 : 32'd4);
        last = cy;
        nrdy++;
        if_addr[1] = 32'(4 * nrdy);
        if (nrdy == 3) if_req[1] = 1'b0;
      end
      step();
    end
    check_eq("s4_ready_count", 32'(nrdy),         32'd3);
    check_eq("s4_pulse_width", 32'(if_ready[1]),  32'd0);
    count_window(1, 6, a, b, c);
    check_eq("s4_no_extra_rdy", 32'(a),           32'd0);
    check_eq("s4_grants",      32'(nen + c),      32'd3);
    check_eq("s4_busy_after",  32'(busy[1]),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
